// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around mem_port_arbiter.
//   slave  : view used by the arbiter (takes requests, drives the memory port)
//   master : view used by the requesters and memory model around it
// Requester side: if_req/if_addr -> if_rdata/if_done/if_stall,
//                 d_req/d_we/d_addr/d_wdata -> d_rdata/d_done/d_stall
// Memory side:    mem_req/mem_we/mem_addr/mem_wdata -> mem_rdata/mem_ack
// Status:         timeout (sticky watchdog flag)
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              if_stall;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              d_stall;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic              timeout;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_done, if_stall, d_rdata, d_done, d_stall,
               mem_req, mem_we, mem_addr, mem_wdata, timeout
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_done, if_stall, d_rdata, d_done, d_stall,
               mem_req, mem_we, mem_addr, mem_wdata, timeout
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (read-only) and
// data access (read/write). Data has fixed priority. Each access runs
// IDLE -> IBUSY/DBUSY -> DONE -> IDLE with a one-cycle done pulse, and a
// watchdog aborts accesses the memory never acknowledges.
// Ports: clk, rst_n (async active-low), bus (mem_port_arbiter_if.slave).
module mem_port_arbiter #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       TIMEOUT_CYC = 1024,
    parameter logic [DATA_W-1:0] ERR_DATA    = DATA_W'(32'hDEADBEEF)
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);
    localparam int unsigned CNT_W = 16;
    localparam bit          WD_EN = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] WD_LAST =
        CNT_W'((TIMEOUT_CYC == 0) ? 32'd0 : TIMEOUT_CYC - 32'd1);

    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, DONE} state_e;

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_done_q, if_done_d;
    logic              d_done_q, d_done_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic              wd_expire;

    assign wd_expire = WD_EN && (wd_cnt_q == WD_LAST);

    // Next-state and output computation
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        timeout_d   = timeout_q;
        wd_cnt_d    = wd_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.d_req) begin
                    state_d     = DBUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    wd_cnt_d    = '0;
                end else if (bus.if_req) begin
                    state_d    = IBUSY;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = bus.if_addr;
                    wd_cnt_d   = '0;
                end
            end
            IBUSY, DBUSY: begin
                // Ack takes precedence over a watchdog expiry in the same cycle
                if (bus.mem_ack || wd_expire) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (!bus.mem_ack) begin
                        timeout_d = 1'b1;
                    end
                    if (state_q == IBUSY) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = bus.mem_ack ? bus.mem_rdata : ERR_DATA;
                    end else begin
                        d_done_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = bus.mem_ack ? bus.mem_rdata : ERR_DATA;
                        end
                    end
                end else begin
                    wd_cnt_d = wd_cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                // Requests still high here are deliberately not re-issued
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            timeout_q   <= 1'b0;
            wd_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            timeout_q   <= timeout_d;
            wd_cnt_q    <= wd_cnt_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.timeout   = timeout_q;

    // Stalls are combinational so the pipeline freezes in the request cycle
    assign bus.if_stall  = bus.if_req & ~if_done_q;
    assign bus.d_stall   = bus.d_req & ~d_done_q;
endmodule
